// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame size, common command bytes
// and the odd-parity helper used when framing a host command.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line plus a falling-edge strobe.
// Flops reset to 1 because an idle, released line is pulled high.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign fall      = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out 8 data
// bits + odd parity + stop on device falling edges, then check the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_sync, clk_fall, data_sync, data_fall_unused;

  ps2_sync u_sync_clk (
    .clk      (clk),
    .rst      (rst),
    .line_in  (ps2_clk),
    .line_sync(clk_sync),
    .fall     (clk_fall)
  );

  ps2_sync u_sync_data (
    .clk      (clk),
    .rst      (rst),
    .line_in  (ps2_data),
    .line_sync(data_sync),
    .fall     (data_fall_unused)
  );

  ps2_state_e        state_q, state_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [8:0]        frame_q, frame_d;
  logic              ack_err_q, ack_err_d;
  logic              clk_drv_q, clk_drv_d;
  logic              data_drv_q, data_drv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic              counting;

  always_comb begin
    state_d    = state_q;
    inh_d      = inh_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    ack_err_d  = ack_err_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    to_d       = 1'b0;
    counting   = state_q inside {REQ, DATA, ACK, WAIT_IDLE};

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d   = {odd_parity(tx_data), tx_data};
          inh_d     = '0;
          clk_drv_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = REQ;
        end else begin
          inh_d = inh_q + INH_W'(1);
        end
      end
      REQ: begin
        if (clk_fall) begin
          data_drv_d = ~frame_q[0];
          frame_d    = {1'b0, frame_q[8:1]};
          bit_cnt_d  = 4'd1;
          state_d    = DATA;
        end
      end
      DATA: begin
        // Nine falls already consumed data+parity; the tenth releases for stop.
        if (clk_fall) begin
          if (bit_cnt_q == 4'd9) begin
            data_drv_d = 1'b0;
            state_d    = ACK;
          end else begin
            data_drv_d = ~frame_q[0];
            frame_d    = {1'b0, frame_q[8:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_err_d = data_sync;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Outcome pulse is issued first; IDLE (and tx_ready) follows a cycle later.
        if (done_q || err_q) begin
          state_d = IDLE;
        end else if (clk_sync && data_sync) begin
          done_d = ~ack_err_q;
          err_d  = ack_err_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (counting && wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1) &&
        !done_d && !err_d && !done_q && !err_q) begin
      clk_drv_d  = 1'b0;
      data_drv_d = 1'b0;
      to_d       = 1'b1;
      state_d    = IDLE;
    end

    if (clk_fall || state_d != state_q || !counting) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inh_q      <= '0;
      wdog_q     <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      ack_err_q  <= 1'b0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      wdog_q     <= wdog_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      ack_err_q  <= ack_err_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign tx_ready           = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign ps2_clk_drive_low  = clk_drv_q;
  assign ps2_data_drive_low = data_drv_q;
  assign tx_done            = done_q;
  assign tx_ack_err         = err_q;
  assign tx_timeout         = to_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending side of the PS/2 link whose receive side (`kbd_ctrl`) decodes keyboard scancodes. It accepts one command byte at a time, for example `0xED` (set LEDs), through a valid/ready handshake. It drives the open-drain PS/2 clock and data lines through pull-low enables, following the host request-to-send protocol, and reports completion, missing acknowledge, or timeout. It sits beside `kbd_ctrl` in `top`, and its `busy` output suppresses the receiver while a transmission is in progress.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: cycles `ps2_clk` is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum cycles between device clock falling edges, and for the bus-idle wait (15 ms at 50 MHz).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: PS/2 clock line, asynchronous.
- `ps2_data` in 1: PS/2 data line, asynchronous.
- `tx_valid` in 1: a command byte is offered.
- `tx_data` in 8: the command byte.
- `tx_ready` out 1: the block can accept a byte; high exactly when in IDLE.
- `ps2_clk_drive_low` out 1: 1 pulls `ps2_clk` low; 0 releases it.
- `ps2_data_drive_low` out 1: 1 pulls `ps2_data` low; 0 releases it.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse when the byte was sent and acknowledged.
- `tx_ack_err` out 1: one-cycle pulse when the device did not acknowledge.
- `tx_timeout` out 1: one-cycle pulse when the transfer was aborted on timeout.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` pass through 2-flop synchronizers. A falling edge (`fall`) is synchronized clock previous = 1 and current = 0.
- **Accept.** A byte is accepted when `tx_valid && tx_ready` at a clock edge. On acceptance the block latches `tx_data`, computes odd parity `par = ~^tx_data`, and enters INHIBIT.
- **INHIBIT.**
  - `ps2_clk_drive_low = 1` for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
- **REQ.**
  - Clock released; `ps2_data_drive_low = 1` (start bit).
  - Bit counter cleared. First `fall` moves to DATA.
- **DATA.**
  - On fall k (k = 1..8), drive bit k-1, LSB first.
  - Encoding is `ps2_data_drive_low = ~bit`.
  - Fall 9 drives `par` (same encoding).
  - Fall 10 releases data (stop bit = 1) and moves to ACK.
- **ACK.** On fall 11, sample synchronized `ps2_data`:
  - 0 means acknowledge OK;
  - 1 means error.
  - In both cases go to WAIT_IDLE, remembering the result.
- **WAIT_IDLE.**
  - Wait until synchronized clock and data are both 1.
  - Then pulse `tx_done` (OK) or `tx_ack_err` (error) and return to IDLE.
- **Outcome pulses.** Exactly one of `tx_done`, `tx_ack_err`, `tx_timeout` pulses per accepted byte.
- **Timeout.**
  - A watchdog counter clears on state entry and on every `fall`, and counts in REQ, DATA, ACK and WAIT_IDLE.
  - When it reaches `TIMEOUT_CYCLES`: release both lines, pulse `tx_timeout`, go to IDLE.
- **During a transfer.** `tx_valid` and `tx_data` are ignored while `busy`.

## Timing
- **Reset.**
  - While `rst` = 0 at an edge: state IDLE, counters 0.
  - `ps2_clk_drive_low`, `ps2_data_drive_low`, `tx_done`, `tx_ack_err`, `tx_timeout` and `busy` are all 0; `tx_ready` = 1.
  - Reset in any state releases both lines by the next edge and emits no outcome pulse.
- **Accept to line activity.** Acceptance at edge N: `ps2_clk_drive_low` is 1 from N+1 through N+`INHIBIT_CYCLES`. At edge N+`INHIBIT_CYCLES`+1 the clock is released and the data line is pulled low in the same cycle.
- **Edge-to-data latency.** Data changes 3 cycles after the physical falling edge (2 synchronizer cycles + 1 register). This is well inside the PS/2 half period (≥30 µs).
- **Outcome pulses.** Each is registered and lasts exactly one cycle; `tx_ready` is 1 on the following cycle.
- **Back-to-back.** A new byte can be accepted on the cycle `tx_ready` returns. There is no internal queue.

## Structure
- **Package `ps2_pkg`.**
  - State enum: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
  - `PS2_FRAME_BITS = 11`.
  - Command constants: `PS2_CMD_SET_LEDS = 8'hED`, `PS2_CMD_RESET = 8'hFF`, `PS2_RESP_ACK = 8'hFA`.
- **Sub-module `ps2_sync`.** 2-flop synchronizer plus falling-edge detector, instantiated once per line. It is shared with `kbd_ctrl`.

## Test plan
The bench uses `INHIBIT_CYCLES=10` and `TIMEOUT_CYCLES=200`, with a device model clocking at a 40-cycle period.

1. **Send `0xED`, device acknowledges.**
   - `ps2_clk_drive_low` is high exactly 10 cycles.
   - Device samples on rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - `tx_done` pulses once; `tx_ack_err` and `tx_timeout` stay 0.
2. **Send `0x01`.** Parity bit sampled as 0. Send `0x00`: parity bit sampled as 1.
3. **Device leaves data high at the 11th clock.** `tx_ack_err` pulses once, no `tx_done`, both drive outputs 0, `tx_ready` = 1.
4. **Device stops clocking after 4 falling edges.** `tx_timeout` pulses 200 cycles after the 4th edge is detected; both lines released.
5. **`tx_valid` held high while busy with `tx_data` changing `0xED`→`0x55`.** Only `0xED` is framed. `0x55` is accepted on the cycle `tx_ready` returns.
6. **`rst` = 0 during DATA bit 3.** Next cycle both drives are 0, no outcome pulse, `tx_ready` = 1.
